bias_ctrl: RTL and testbench
============================

BIAS_CTRL -- requirements
Module: bias_ctrl

Interface
REQ-001 SHALL have parameter KNUM_W, default 10, width of kernel-group index and count.
REQ-002 SHALL have parameter START_TO, default 16, cycles allowed for bias_top to raise busy after a start request.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins one bias load/read sequence.
REQ-006 cfg_groups  input  KNUM_W  kernel groups per sequence; value 0 SHALL be treated as 1; sampled on accepted start.
REQ-007 cfg_skip_write  input  1  1 = bias already resident, skip write phase; sampled on accepted start.
REQ-008 group_adv  input  1  pulse from kernel-read side: current kernel group finished.
REQ-009 bias_write_busy, bias_write_done, bias_read_busy, bias_read_done  input  1 each  status from bias_top.
REQ-010 start_bias_write, start_bias_read  output  1 each  start requests to bias_top.
REQ-011 sram_rw  output  1  1 = bias SRAM in write mode, 0 = read mode.
REQ-012 en_ker_num  output  1  one-cycle pulse announcing a group change.
REQ-013 cp_ker_num  output  KNUM_W  current kernel-group index.
REQ-014 ker_read_done  output  1  all groups consumed.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at sequence end.
REQ-017 err  output  1  sticky protocol error flag.

Function
REQ-018 FSM states SHALL be IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_RUN, ADV, RD_FIN, DONE.
REQ-019 IDLE: start=1 SHALL latch config, clear err, cp_ker_num=0, and go to RD_REQ if cfg_skip_write=1, else WR_REQ; start outside IDLE SHALL be ignored.
REQ-020 WR_REQ: sram_rw=1 and start_bias_write=1 held until the first cycle bias_write_busy=1, then WR_WAIT; start_bias_write SHALL be low from that cycle.
REQ-021 WR_WAIT: sram_rw=1; on bias_write_done=1 go to RD_REQ with sram_rw=0 from the next cycle.
REQ-022 RD_REQ: start_bias_read held until bias_read_busy=1, then RD_RUN.
REQ-023 REQ/timeout: if busy is not seen within START_TO cycles in WR_REQ or RD_REQ, the FSM SHALL set err, drop the start request, and go to IDLE without a done pulse.
REQ-024 RD_RUN: group_adv=1 with cp_ker_num < groups-1 SHALL go to ADV; with cp_ker_num = groups-1 SHALL go to RD_FIN.
REQ-025 ADV: en_ker_num=1 for exactly this cycle; cp_ker_num SHALL increment by 1 on the following edge (visible the cycle after the en pulse); return to RD_RUN.
REQ-026 RD_FIN: ker_read_done=1 held until bias_read_done=1, then DONE.
REQ-027 DONE: done=1 for one cycle, then IDLE; cp_ker_num SHALL hold its last value until the next accepted start.
REQ-028 group_adv in any state other than RD_RUN SHALL be ignored and SHALL set err.
REQ-029 cp_ker_num SHALL never exceed groups-1 and SHALL never wrap.
REQ-030 sram_rw SHALL be 0 in all states except WR_REQ and WR_WAIT.
REQ-031 bias_write_done or bias_read_done arriving outside its waiting state SHALL be ignored without error.

Reset
REQ-032 rstn=0 SHALL force IDLE asynchronously and set all outputs to 0, including cp_ker_num=0 and err=0.
REQ-033 Reset mid-sequence SHALL abort with no done pulse; the first start after rstn rises SHALL be accepted normally.

Verification
REQ-034 cfg_groups=8, skip=0, busy seen 2 cycles after each request, adv pulses every 20 cycles -> sram_rw=1 only in write phase, 7 en pulses, cp_ker_num 0..7, ker_read_done held until bias_read_done, one done pulse.
REQ-035 cfg_skip_write=1, cfg_groups=1 -> start_bias_write never asserts; one adv goes directly to RD_FIN; en_ker_num never pulses; cp_ker_num stays 0.
REQ-036 cfg_groups=0 -> behaves exactly as cfg_groups=1.
REQ-037 bias_read_busy held low after RD_REQ -> start_bias_read high for exactly 16 cycles, then err=1, FSM in IDLE, no done pulse.
REQ-038 group_adv injected during ADV and during WR_WAIT -> ignored, cp_ker_num unchanged, err=1 until next start.
REQ-039 rstn pulsed low during RD_RUN at cp_ker_num=3 -> all outputs 0 immediately; a new start then completes normally.

Source files
------------

// File: rtl/bias_ctrl.sv
// bias_ctrl: sequences bias SRAM write/read via bias_top and steps the kernel-group index.
// Start requests are held until bias_top reports busy, or abandoned with err after START_TO cycles.
module bias_ctrl #(
   parameter int KNUM_W   = 10,
   parameter int START_TO = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [KNUM_W-1:0] cfg_groups,
   input  logic              cfg_skip_write,
   input  logic              group_adv,
   input  logic              bias_write_busy,
   input  logic              bias_write_done,
   input  logic              bias_read_busy,
   input  logic              bias_read_done,
   output logic              start_bias_write,
   output logic              start_bias_read,
   output logic              sram_rw,
   output logic              en_ker_num,
   output logic [KNUM_W-1:0] cp_ker_num,
   output logic              ker_read_done,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int TW = $clog2(START_TO + 1);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_RUN, ADV, RD_FIN, DONE} state_t;

   state_t            state, next;
   logic [KNUM_W-1:0] last;
   logic [TW-1:0]     to_cnt;
   logic              accept, req_st, req_ack, timeout, stray_adv;

   assign accept    = state == IDLE && start;
   assign req_st    = state == WR_REQ || state == RD_REQ;
   assign req_ack   = state == WR_REQ ? bias_write_busy : bias_read_busy;
   assign timeout   = req_st && !req_ack && to_cnt == TW'(START_TO - 1);
   assign stray_adv = group_adv && state != RD_RUN;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= next;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         to_cnt     <= '0;
         last       <= '0;
         cp_ker_num <= '0;
         err        <= 1'b0;
      end else begin
         to_cnt     <= req_st && !req_ack ? to_cnt + TW'(1) : '0;
         // a zero group count is stored as one group (last index 0)
         last       <= accept ? (cfg_groups == '0 ? '0 : cfg_groups - KNUM_W'(1)) : last;
         cp_ker_num <= accept ? '0 : state == ADV ? cp_ker_num + KNUM_W'(1) : cp_ker_num;
         err        <= accept ? 1'b0 : (timeout || stray_adv) ? 1'b1 : err;
      end
   end

   always_comb begin
      next             = state;
      start_bias_write = 1'b0;
      start_bias_read  = 1'b0;
      sram_rw          = 1'b0;
      en_ker_num       = 1'b0;
      ker_read_done    = 1'b0;
      done             = 1'b0;
      busy             = state != IDLE;
      case (state)
         IDLE:    next = !start ? IDLE : cfg_skip_write ? RD_REQ : WR_REQ;
         WR_REQ: begin
            sram_rw          = 1'b1;
            start_bias_write = !bias_write_busy;
            next             = bias_write_busy ? WR_WAIT : timeout ? IDLE : WR_REQ;
         end
         WR_WAIT: begin
            sram_rw = 1'b1;
            next    = bias_write_done ? RD_REQ : WR_WAIT;
         end
         RD_REQ: begin
            start_bias_read = !bias_read_busy;
            next            = bias_read_busy ? RD_RUN : timeout ? IDLE : RD_REQ;
         end
         RD_RUN:  next = !group_adv ? RD_RUN : cp_ker_num == last ? RD_FIN : ADV;
         ADV: begin
            en_ker_num = 1'b1;
            next       = RD_RUN;
         end
         RD_FIN: begin
            ker_read_done = 1'b1;
            next          = bias_read_done ? DONE : RD_FIN;
         end
         DONE: begin
            done = 1'b1;
            next = IDLE;
         end
         default: next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_bias_ctrl.sv
// tb_bias_ctrl: directed sequences against a bias_top responder; events checked through a scoreboard.
module tb_bias_ctrl;
   localparam int KNUM_W = 10;
   localparam int EV_EN = 0, EV_DONE = 1, EV_ERR = 2;

   logic              clk = 1'b0, rstn = 1'b0, start = 1'b0, cfg_skip_write = 1'b0, group_adv = 1'b0;
   logic [KNUM_W-1:0] cfg_groups = '0;
   logic              bias_write_busy = 1'b0, bias_write_done = 1'b0, bias_read_busy = 1'b0, bias_read_done = 1'b0;
   logic              start_bias_write, start_bias_read, sram_rw, en_ker_num, ker_read_done, busy, done, err;
   logic [KNUM_W-1:0] cp_ker_num;

   int checks = 0, errors = 0;
   int exp_q[$];
   int cnt_wr, cnt_rd, cnt_sram, cnt_krd, cnt_done;
   bit wr_resp = 1, rd_resp = 1;
   int wr_st = 0, wr_cnt = 0, rd_st = 0, rd_cnt = 0;

   bias_ctrl #(.KNUM_W(KNUM_W), .START_TO(16)) dut (
      .clk(clk), .rstn(rstn), .start(start), .cfg_groups(cfg_groups), .cfg_skip_write(cfg_skip_write),
      .group_adv(group_adv), .bias_write_busy(bias_write_busy), .bias_write_done(bias_write_done),
      .bias_read_busy(bias_read_busy), .bias_read_done(bias_read_done), .start_bias_write(start_bias_write),
      .start_bias_read(start_bias_read), .sram_rw(sram_rw), .en_ker_num(en_ker_num), .cp_ker_num(cp_ker_num),
      .ker_read_done(ker_read_done), .busy(busy), .done(done), .err(err));

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_ev(input int kind, input int val);
      exp_q.push_back(kind * 1024 + val);
   endtask

   task automatic got_ev(input int kind, input int val);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: got kind %0d val %0d with empty queue at %0t", kind, val, $time);
      end else check("event", kind * 1024 + val, exp_q.pop_front());
   endtask

   // bias_top responder: busy 2 cycles after a request, write finishes on its own,
   // read finishes 2 cycles after ker_read_done
   initial forever begin
      @(posedge clk); #1;
      if (!rstn) begin
         wr_st = 0; rd_st = 0;
         bias_write_busy = 0; bias_write_done = 0; bias_read_busy = 0; bias_read_done = 0;
      end else begin
         case (wr_st)
            0: if (start_bias_write && wr_resp) begin wr_cnt = 0; wr_st = 1; end
            1: begin wr_cnt++; if (wr_cnt == 2) begin bias_write_busy = 1; wr_cnt = 0; wr_st = 2; end end
            2: begin wr_cnt++; if (wr_cnt == 3) begin bias_write_busy = 0; bias_write_done = 1; wr_st = 3; end end
            default: begin bias_write_done = 0; wr_st = 0; end
         endcase
         case (rd_st)
            0: if (start_bias_read && rd_resp) begin rd_cnt = 0; rd_st = 1; end
            1: begin rd_cnt++; if (rd_cnt == 2) begin bias_read_busy = 1; rd_st = 2; end end
            2: if (ker_read_done) begin rd_cnt = 0; rd_st = 3; end
            3: begin rd_cnt++; if (rd_cnt == 2) begin bias_read_busy = 0; bias_read_done = 1; rd_st = 4; end end
            default: begin bias_read_done = 0; rd_st = 0; end
         endcase
      end
   end

   initial begin
      bit prev_err = 0, pend_en = 0;
      int en_val = 0;
      forever begin
         @(negedge clk);
         if (pend_en) check("cp_after_en", int'(cp_ker_num), en_val + 1);
         pend_en = en_ker_num;
         en_val  = int'(cp_ker_num);
         if (en_ker_num) got_ev(EV_EN, int'(cp_ker_num));
         if (done) begin got_ev(EV_DONE, int'(cp_ker_num)); cnt_done++; end
         if (err && !prev_err) got_ev(EV_ERR, int'(cp_ker_num));
         prev_err = err;
         cnt_wr   += int'(start_bias_write);
         cnt_rd   += int'(start_bias_read);
         cnt_sram += int'(sram_rw);
         cnt_krd  += int'(ker_read_done);
      end
   end

   task automatic clr();
      cnt_wr = 0; cnt_rd = 0; cnt_sram = 0; cnt_krd = 0; cnt_done = 0;
   endtask

   task automatic pulse_start(input int g, input bit s);
      @(posedge clk); #1;
      cfg_groups = KNUM_W'(g); cfg_skip_write = s; start = 1;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic adv(input int cycles);
      repeat (20) @(posedge clk);
      #1 group_adv = 1;
      repeat (cycles) @(posedge clk);
      #1 group_adv = 0;
   endtask

   task automatic wait_for(input string name, input int which, input int budget);
      bit seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk); #1;
         seen = which == 0 ? bias_read_busy : which == 1 ? bias_write_busy : !busy;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s: got not-seen expected seen within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_done(input int budget);
      bit seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL timeout_done: got no done expected done within %0d cycles", budget);
      end
      @(posedge clk); #1;
   endtask

   task automatic check_zero(input string name);
      check({name, "_outs"}, int'({start_bias_write, start_bias_read, sram_rw, en_ker_num,
                                   ker_read_done, busy, done, err}), 0);
      check({name, "_cp"}, int'(cp_ker_num), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      #3 check_zero("reset");
      repeat (2) @(posedge clk);
      #1 rstn = 1;

      // full sequence, 8 groups with write phase
      clr();
      for (int i = 0; i < 7; i++) expect_ev(EV_EN, i);
      expect_ev(EV_DONE, 7);
      pulse_start(8, 0);
      wait_for("rd_busy", 0, 100);
      for (int i = 0; i < 8; i++) adv(1);
      wait_done(100);
      check("seq8_sram_cycles", cnt_sram, 6);
      check("seq8_wr_req_cycles", cnt_wr, 2);
      check("seq8_rd_req_cycles", cnt_rd, 2);
      check("seq8_krd_cycles", cnt_krd, 3);
      check("seq8_cp_hold", int'(cp_ker_num), 7);
      check("seq8_idle", int'({busy, err}), 0);
      check("seq8_queue", exp_q.size(), 0);

      // skip write, single group
      clr();
      expect_ev(EV_DONE, 0);
      pulse_start(1, 1);
      wait_for("rd_busy", 0, 100);
      adv(1);
      wait_done(100);
      check("skip_wr_req_cycles", cnt_wr, 0);
      check("skip_sram_cycles", cnt_sram, 0);
      check("skip_cp", int'(cp_ker_num), 0);
      check("skip_queue", exp_q.size(), 0);

      // zero groups behaves as one group
      clr();
      expect_ev(EV_DONE, 0);
      pulse_start(0, 0);
      wait_for("rd_busy", 0, 100);
      adv(1);
      wait_done(100);
      check("g0_sram_cycles", cnt_sram, 6);
      check("g0_krd_cycles", cnt_krd, 3);
      check("g0_cp", int'(cp_ker_num), 0);
      check("g0_queue", exp_q.size(), 0);

      // read busy never arrives -> timeout
      clr();
      rd_resp = 0;
      expect_ev(EV_ERR, 0);
      pulse_start(5, 1);
      wait_for("idle", 2, 100);
      repeat (3) @(posedge clk);
      #1 rd_resp = 1;
      check("to_rd_req_cycles", cnt_rd, 16);
      check("to_err", int'(err), 1);
      check("to_busy", int'(busy), 0);
      check("to_no_done", cnt_done, 0);
      check("to_queue", exp_q.size(), 0);

      // stray group_adv in WR_WAIT and in ADV
      clr();
      expect_ev(EV_ERR, 0);
      for (int i = 0; i < 3; i++) expect_ev(EV_EN, i);
      expect_ev(EV_DONE, 3);
      pulse_start(4, 0);
      wait_for("wr_busy", 1, 100);
      @(posedge clk); #1 group_adv = 1;
      @(posedge clk); #1 group_adv = 0;
      check("stray_wr_err", int'(err), 1);
      wait_for("rd_busy", 0, 100);
      adv(2);
      for (int i = 0; i < 3; i++) adv(1);
      wait_done(100);
      check("stray_cp", int'(cp_ker_num), 3);
      check("stray_err_sticky", int'(err), 1);
      check("stray_queue", exp_q.size(), 0);

      // reset in RD_RUN at cp 3, then a normal sequence
      clr();
      for (int i = 0; i < 3; i++) expect_ev(EV_EN, i);
      pulse_start(8, 1);
      check("start_clears_err", int'(err), 0);
      wait_for("rd_busy", 0, 100);
      for (int i = 0; i < 3; i++) adv(1);
      repeat (5) @(posedge clk);
      #1 check("pre_reset_cp", int'(cp_ker_num), 3);
      #1 rstn = 0;
      #1 check_zero("midreset");
      check("midreset_queue", exp_q.size(), 0);
      @(posedge clk); #1 rstn = 1;
      clr();
      expect_ev(EV_DONE, 0);
      pulse_start(1, 1);
      wait_for("rd_busy", 0, 100);
      adv(1);
      wait_done(100);
      check("post_reset_done", cnt_done, 1);
      check("post_reset_queue", exp_q.size(), 0);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
